// File: rtl/uart_tx_frame_arbiter.sv
// Round-robin arbiter sharing one UART TX byte stream between NUM_REQ framed requesters.
// Latency: one idle bubble per frame, then the granted byte passes combinationally; out_ready feeds straight back to the granted req_ready.
module uart_tx_frame_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_FRAME = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       frame_abort
);
    localparam int GNT_W = $clog2(NUM_REQ);
    localparam logic [7:0] BYTE_LIM = 8'(MAX_FRAME - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_nxt;
    logic [GNT_W-1:0]   ptr, ptr_nxt;
    logic [GNT_W-1:0]   grant_nxt;
    logic [7:0]         byte_cnt, cnt_nxt;
    logic               abort_nxt;

    logic [DATA_W-1:0]  data_arr [NUM_REQ];
    logic               sel_found;
    logic [GNT_W-1:0]   sel_idx;
    logic [GNT_W:0]     scan_sum;
    logic [GNT_W-1:0]   scan_idx;
    logic [GNT_W-1:0]   next_ptr;
    logic               last_byte;
    logic               xfer;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, ptr} + (GNT_W+1)'(k);
            if (scan_sum >= (GNT_W+1)'(NUM_REQ))
                scan_sum = scan_sum - (GNT_W+1)'(NUM_REQ);
            scan_idx = scan_sum[GNT_W-1:0];
            if (!sel_found && req_valid[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    assign next_ptr  = (grant_id == GNT_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign last_byte = (byte_cnt == BYTE_LIM);
    assign xfer      = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = grant_id;
        cnt_nxt   = byte_cnt;
        abort_nxt = 1'b0;
        req_ready = '0;
        out_data  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    grant_nxt = sel_idx;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                busy                = 1'b1;
                out_data            = data_arr[grant_id];
                out_valid           = req_valid[grant_id];
                out_last            = req_last[grant_id] | last_byte;
                req_ready[grant_id] = out_ready;
                if (xfer) begin
                    cnt_nxt = byte_cnt + 8'd1;
                    // Frame ends on a real last or when the byte budget runs out.
                    if (req_last[grant_id] || last_byte) begin
                        state_nxt = IDLE;
                        ptr_nxt   = next_ptr;
                        abort_nxt = !req_last[grant_id];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_id    <= '0;
            byte_cnt    <= '0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            grant_id    <= grant_nxt;
            byte_cnt    <= cnt_nxt;
            frame_abort <= abort_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Directed bench for uart_tx_frame_arbiter built with MAX_FRAME=4 so the forced release is reachable.
module tb_uart_tx_frame_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0] req_valid = '0;
    logic [NR-1:0] req_last = '0;
    logic [NR-1:0] req_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready = 1'b0;
    logic [1:0]    grant_id;
    logic          busy;
    logic          frame_abort;

    int checks = 0;
    int failures = 0;

    uart_tx_frame_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_FRAME(4)) dut (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(req_ready), .out_data(out_data),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .grant_id(grant_id), .busy(busy), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int r, input logic [7:0] d, input logic v, input logic l);
        req_data[r*DW +: DW] = d;
        req_valid[r] = v;
        req_last[r]  = l;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (frame_abort !== 1'b0) begin failures++; $display("FAIL reset_abort got=%b exp=0", frame_abort); end
        cyc(); rst = 1'b0;
        out_ready = 1'b1;
        set_req(2, 8'h55, 1'b1, 1'b0);
        cyc(); cyc(); #1;
        checks++; if (grant_id !== 2'd2 || busy !== 1'b1) begin failures++; $display("FAIL mid_grant got gid=%0d busy=%b exp gid=2 busy=1", grant_id, busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || req_ready !== 4'b0 || grant_id !== 2'd0)
            begin failures++; $display("FAIL async_reset got busy=%b vld=%b rdy=%b gid=%0d exp 0/0/0000/0", busy, out_valid, req_ready, grant_id); end
        clear_reqs();
        cyc(); rst = 1'b0;
    endtask

    task automatic test_single_frame();
        cyc(); set_req(1, 8'hA1, 1'b1, 1'b0); out_ready = 1'b1; #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL single_bubble got busy=%b vld=%b exp 0/0", busy, out_valid); end
        cyc(); #1;
        checks++; if (out_data !== 8'hA1 || out_valid !== 1'b1 || out_last !== 1'b0 || req_ready !== 4'b0010 || grant_id !== 2'd1)
            begin failures++; $display("FAIL single_b0 got d=%h v=%b l=%b rdy=%b gid=%0d exp A1/1/0/0010/1", out_data, out_valid, out_last, req_ready, grant_id); end
        cyc(); set_req(1, 8'hA2, 1'b1, 1'b0); #1;
        checks++; if (out_data !== 8'hA2 || out_last !== 1'b0) begin failures++; $display("FAIL single_b1 got d=%h l=%b exp A2/0", out_data, out_last); end
        cyc(); set_req(1, 8'hA3, 1'b1, 1'b1); #1;
        checks++; if (out_data !== 8'hA3 || out_last !== 1'b1) begin failures++; $display("FAIL single_b2 got d=%h l=%b exp A3/1", out_data, out_last); end
        cyc(); clear_reqs(); #1;
        checks++; if (busy !== 1'b0 || frame_abort !== 1'b0) begin failures++; $display("FAIL single_end got busy=%b abort=%b exp 0/0", busy, frame_abort); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [8] = '{8'h00, 8'h01, 8'h20, 8'h21, 8'h02, 8'h03, 8'h22, 8'h23};
        logic [1:0] exp_g [8] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd2};
        int seq [NR] = '{0, 0, 0, 0};
        int n = 0;
        pulse_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 40 && n < 8; c++) begin
            cyc();
            set_req(0, 8'(seq[0]), 1'b1, seq[0][0]);
            set_req(2, 8'h20 + 8'(seq[2]), 1'b1, seq[2][0]);
            #1;
            if ($countones(req_ready) > 1) begin
                checks++; failures++; $display("FAIL rr_onehot got rdy=%b", req_ready);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== exp_d[n] || grant_id !== exp_g[n]) begin
                    failures++; $display("FAIL rr_xfer%0d got d=%h gid=%0d exp d=%h gid=%0d", n, out_data, grant_id, exp_d[n], exp_g[n]);
                end
                n++;
                for (int r = 0; r < NR; r++) if (req_ready[r]) seq[r]++;
            end
        end
        checks++; if (n != 8) begin failures++; $display("FAIL rr_count got=%0d exp=8", n); end
        cyc(); clear_reqs();
        cyc();
    endtask

    task automatic test_backpressure();
        cyc(); set_req(0, 8'hB0, 1'b1, 1'b0); out_ready = 1'b1;
        cyc(); #1;
        checks++; if (out_data !== 8'hB0 || grant_id !== 2'd0) begin failures++; $display("FAIL bp_b0 got d=%h gid=%0d exp B0/0", out_data, grant_id); end
        cyc(); set_req(0, 8'hB1, 1'b1, 1'b0); out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out_data !== 8'hB1 || out_valid !== 1'b1 || req_ready !== 4'b0)
                begin failures++; $display("FAIL bp_stall%0d got d=%h v=%b rdy=%b exp B1/1/0000", i, out_data, out_valid, req_ready); end
            cyc();
        end
        out_ready = 1'b1; #1;
        checks++; if (out_data !== 8'hB1 || req_ready !== 4'b0001 || out_last !== 1'b0)
            begin failures++; $display("FAIL bp_resume got d=%h rdy=%b l=%b exp B1/0001/0", out_data, req_ready, out_last); end
        cyc(); set_req(0, 8'hB2, 1'b1, 1'b1); #1;
        checks++; if (out_data !== 8'hB2 || out_last !== 1'b1) begin failures++; $display("FAIL bp_b2 got d=%h l=%b exp B2/1", out_data, out_last); end
        cyc(); clear_reqs(); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_end got busy=%b exp 0", busy); end
    endtask

    task automatic test_forced_release();
        cyc(); set_req(3, 8'hC0, 1'b1, 1'b0); set_req(0, 8'hD0, 1'b1, 1'b1); out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(); set_req(3, 8'hC0 + 8'(i), 1'b1, 1'b0); #1;
            checks++; if (out_data !== 8'hC0 + 8'(i) || grant_id !== 2'd3 || out_last !== (i == 3) || frame_abort !== 1'b0)
                begin failures++; $display("FAIL fr_b%0d got d=%h gid=%0d l=%b ab=%b exp d=%h gid=3 l=%b ab=0", i, out_data, grant_id, out_last, frame_abort, 8'hC0 + 8'(i), (i == 3)); end
        end
        cyc(); #1;
        checks++; if (frame_abort !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL fr_abort got ab=%b busy=%b exp 1/0", frame_abort, busy); end
        cyc(); #1;
        checks++; if (frame_abort !== 1'b0 || grant_id !== 2'd0 || out_data !== 8'hD0)
            begin failures++; $display("FAIL fr_next got ab=%b gid=%0d d=%h exp 0/0/D0", frame_abort, grant_id, out_data); end
        cyc(); clear_reqs();
    endtask

    task automatic test_valid_gap();
        cyc(); set_req(1, 8'hE0, 1'b1, 1'b0); set_req(0, 8'hF0, 1'b1, 1'b1); out_ready = 1'b1;
        cyc(); #1;
        checks++; if (grant_id !== 2'd1 || out_data !== 8'hE0) begin failures++; $display("FAIL gap_b0 got gid=%0d d=%h exp 1/E0", grant_id, out_data); end
        for (int i = 0; i < 5; i++) begin
            cyc(); set_req(1, 8'hE1, 1'b0, 1'b0); #1;
            checks++; if (busy !== 1'b1 || grant_id !== 2'd1 || out_valid !== 1'b0 || req_ready !== 4'b0010)
                begin failures++; $display("FAIL gap_hold%0d got busy=%b gid=%0d v=%b rdy=%b exp 1/1/0/0010", i, busy, grant_id, out_valid, req_ready); end
        end
        cyc(); set_req(1, 8'hE1, 1'b1, 1'b1); #1;
        checks++; if (out_data !== 8'hE1 || out_last !== 1'b1 || grant_id !== 2'd1) begin failures++; $display("FAIL gap_last got d=%h l=%b gid=%0d exp E1/1/1", out_data, out_last, grant_id); end
        cyc(); set_req(1, 8'h00, 1'b0, 1'b0); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gap_bubble got busy=%b exp 0", busy); end
        cyc(); #1;
        checks++; if (grant_id !== 2'd0 || out_data !== 8'hF0) begin failures++; $display("FAIL gap_next got gid=%0d d=%h exp 0/F0", grant_id, out_data); end
        cyc(); clear_reqs();
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_forced_release();
        test_valid_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
